// File: rtl/cmp_arbiter_pkg.sv
// Shared definitions for the cmp_arbiter block: operation codes and FSM states.
package cmp_arbiter_pkg;

  // Operation codes carried on reqN_op
  localparam logic [1:0] OP_SUB  = 2'b00;
  localparam logic [1:0] OP_SLT  = 2'b01;
  localparam logic [1:0] OP_SLTU = 2'b10;
  localparam logic [1:0] OP_EQ   = 2'b11;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage : cmp_arbiter_pkg

// File: rtl/subtract_32_bit.sv
// Shared subtractor: diff = a + ~b + 1, cout is the carry out of that sum
// (cout = 1 means no borrow, i.e. a >= b unsigned).
module subtract_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             cout
);

  logic [WIDTH:0] sum_s;

  assign sum_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign diff  = sum_s[WIDTH-1:0];
  assign cout  = sum_s[WIDTH];

endmodule : subtract_32_bit

// File: rtl/cmp_arbiter.sv
// Two-requester arbiter in front of one shared subtract/compare unit.
// Round-robin grant in IDLE, one-cycle execute, response held until acked.
// Compile option CMP_ARBITER_OVF_FIX_EN: when defined, signed set-less-than
// corrects the sign bit for subtraction overflow; when undefined, the raw
// sign bit of the difference is used (legacy slt behaviour).
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready
);

  state_e           state_q, state_d;
  logic             prio_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_valid_q;

  logic             grant_any_s;
  logic             grant_id_s;
  logic             accept_s;
  logic [WIDTH-1:0] diff_s;
  logic             cout_s;
  logic             lt_s;
  logic [WIDTH-1:0] result_s;

  subtract_32_bit #(.WIDTH(WIDTH)) u_sub (
    .a    (a_q),
    .b    (b_q),
    .diff (diff_s),
    .cout (cout_s)
  );

`ifdef CMP_ARBITER_OVF_FIX_EN
  logic ovf_s;
  assign ovf_s = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_s[WIDTH-1] != a_q[WIDTH-1]);
  assign lt_s  = diff_s[WIDTH-1] ^ ovf_s;
`else
  assign lt_s  = diff_s[WIDTH-1];
`endif

  // Round-robin grant: a lone requester wins, a tie goes to prio_q
  always_comb begin
    grant_any_s = req0_valid | req1_valid;
    grant_id_s  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id_s = prio_q;
    end else begin
      grant_id_s = req1_valid;
    end
  end

  // Accept only in IDLE; a cycle with reset asserted never accepts
  assign accept_s   = (state_q == S_IDLE) && grant_any_s && !reset;
  assign req0_ready = accept_s && (grant_id_s == 1'b0);
  assign req1_ready = accept_s && (grant_id_s == 1'b1);

  // Result select from the shared subtractor outputs
  always_comb begin
    result_s = diff_s;
    case (op_q)
      OP_SUB:  result_s = diff_s;
      OP_SLT:  result_s = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: result_s = {{(WIDTH-1){1'b0}}, ~cout_s};
      OP_EQ:   result_s = {{(WIDTH-1){1'b0}}, (diff_s == {WIDTH{1'b0}})};
      default: result_s = diff_s;
    endcase
  end

  // Next-state logic; rsp_ready only matters in RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any_s) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, priority pointer, latched operands and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prio_q      <= 1'b0;
      op_q        <= OP_SUB;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      id_q        <= 1'b0;
      rsp_data_q  <= {WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            id_q <= grant_id_s;
            if (grant_id_s) begin
              op_q <= req1_op;
              a_q  <= req1_a;
              b_q  <= req1_b;
            end else begin
              op_q <= req0_op;
              a_q  <= req0_a;
              b_q  <= req0_b;
            end
          end
        end
        S_EXEC: begin
          rsp_data_q  <= result_s;
          rsp_valid_q <= 1'b1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            prio_q      <= ~id_q;
          end
        end
        default: rsp_valid_q <= 1'b0;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;

endmodule : cmp_arbiter

// File: doc/cmp_arbiter.md
# cmp_arbiter

- **Function:** arbitrates two requesters for one shared 32-bit subtract/compare unit.
- **Requesters:** the ALU compare path and the branch-compare path.
- **Operations:** SUB, signed set-less-than, unsigned set-less-than or equality.
- **Schedule:** operands are registered, the operation runs in one cycle, and the result is held on a single response port until it is acknowledged.
- **Purpose:** only one subtractor instance is needed in the multi-cycle MIPS datapath.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.

Ports:
- `clk` input, 1: single clock; all state updates on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `req0_valid` / `req1_valid` input, 1: requester n has an operation pending.
- `req0_ready` / `req1_ready` output, 1: requester n's operation is accepted this cycle.
- `req0_op` / `req1_op` input, 2: operation code. 00 = SUB, 01 = SLT, 10 = SLTU, 11 = EQ.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` input, WIDTH: operands.
- `rsp_valid` output, 1: response is held valid.
- `rsp_id` output, 1: index of the requester that owns the response.
- `rsp_data` output, WIDTH: result.
- `rsp_ready` input, 1: the consumer accepts the response.

## Operation
State machine with three states: IDLE, EXEC and RESP.

- **IDLE**
  - If any `reqN_valid` is high, grant one requester, latch its op/a/b and id, assert that `reqN_ready` combinationally this cycle, then go to EXEC.
  - Otherwise stay in IDLE.
- **Grant rule:** round-robin.
  - A priority pointer `prio` (reset 0) names the favoured requester.
  - If only one requester is valid, it wins.
  - If both are valid, `prio` wins.
- **EXEC**
  - The subtractor computes diff = a − b on the latched operands, giving `diff` and carry-out `cout` (a + ~b + 1).
  - Result selection:
    - SUB → `diff`.
    - SLT → {31'b0, lt_s}.
    - SLTU → {31'b0, ~cout}.
    - EQ → {31'b0, diff == 0}.
  - Register the result into `rsp_data` and go to RESP.
- **RESP**
  - `rsp_valid` = 1; `rsp_data` and `rsp_id` are stable.
  - On `rsp_ready` = 1: set `prio` to ~`rsp_id`, then go to IDLE.
- **Ready outputs:** both `reqN_ready` are 0 outside IDLE.
  - A requester must hold valid and operands until it sees ready.
- **Arithmetic:** modulo 2^WIDTH; no exceptions are raised for overflow.
- **Reset (in any state, including mid-operation):**
  - State goes to IDLE and `prio` to 0.
  - `rsp_valid`, `rsp_id`, `rsp_data` and both ready outputs go to 0.
  - An in-flight operation is discarded with no response.

## Timing
- **Accept to response:** an operation accepted at edge T has `rsp_valid` high from cycle T+2.
- **Throughput:** at most one operation per 3 cycles. An operation is never accepted in the same cycle as a response is retired.
- **Back-pressure:** `rsp_valid` stays high with stable data for any number of cycles while `rsp_ready` = 0.
- **Stray acknowledge:** `rsp_ready` is ignored outside RESP.
- **Simultaneous requests:** when both requesters are valid in IDLE, exactly one ready is asserted.
- **Persistent requesters:** alternate strictly.

## Configuration
The single compile-time option is `CMP_ARBITER_OVF_FIX_EN`.

- **Defined:** lt_s = diff[WIDTH-1] XOR ovf.
  - ovf = (a[MSB] ≠ b[MSB]) && (diff[MSB] ≠ a[MSB]).
  - SLT is correct for all signed inputs.
- **Undefined:** lt_s = diff[WIDTH-1].
  - This is the raw sign bit, matching the existing slt datapath.
  - SLT is wrong when a − b overflows.

## Structure
- **Shared package/include `cmp_arbiter_pkg`:**
  - Opcode constants OP_SUB, OP_SLT, OP_SLTU and OP_EQ.
  - State encodings S_IDLE, S_EXEC and S_RESP.
- **Sub-module:** one instance of the existing `subtract_32_bit` (a, b, diff, cout) as the shared unit.
- **Arbiter logic:** grant logic and the FSM stay inline in `cmp_arbiter`.

## Test plan
- **Single SUB:** req0 SUB a=5, b=7 → `req0_ready` in the same cycle; 2 cycles later `rsp_valid`, `rsp_id`=0, `rsp_data`=0xFFFFFFFE.
- **Contention:** req0 and req1 valid together after reset → req0 is granted first, then req1. With both held valid, the grants continue 0, 1, 0, 1.
- **SLT overflow:** a=0x80000000, b=1 → `rsp_data`=1 with `CMP_ARBITER_OVF_FIX_EN` defined, 0 without. SLTU on the same operands → 0.
- **EQ and SLTU:** EQ a=b=0x1234 → 1. SLTU a=1, b=0xFFFFFFFF → 1. SLT on the same operands → 0.
- **Back-pressure:** `rsp_ready` held 0 for 5 cycles → `rsp_valid` and data stay stable and no `reqN_ready` is asserted. After `rsp_ready` = 1, IDLE is reached on the next cycle.
- **Reset mid-operation:** `reset` asserted in EXEC → next cycle all outputs are 0 and the state is IDLE. No stale response appears, and the next request after reset grants req0 on a tie.
